dpi_txn_arbiter: RTL and testbench

Round-robin arbiter and buffer that shares the single DPI object-send channel between several APB2 bench requesters (monitors, scoreboard taps). Each requester presents a tagged record with a valid/ready handshake. Granted records are queued in a small first-word-fall-through FIFO. A single drain port feeds the bench-side process that serialises each record and calls `dpi_send_object`, one record per call.

---
 rtl/dpi_txn_arbiter.sv | 130 +++++++++++++
 tb/tb_dpi_txn_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_txn_arbiter.sv
// Round-robin arbiter feeding a first-word-fall-through FIFO that serialises bench records onto one drain port.
// Optional full-stall counter enabled by defining DPI_ARB_STALL_CNT_EN.
module dpi_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TAG_W-1:0]              out_tag,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_src,
    output logic [$clog2(DEPTH):0]        level,
    output logic [15:0]                   stall_cnt
);
    localparam int SRC_W   = $clog2(NUM_REQ);
    localparam int SUM_W   = SRC_W + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = SRC_W + TAG_W + DATA_W;

    logic [SRC_W-1:0]   rr_reg;
    logic [SRC_W-1:0]   rr_next;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;
    logic [SUM_W-1:0]   scan_sum;
    logic [SRC_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic               full;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    assign full = (level_reg == LVL_W'(DEPTH));
    // PRESETn gates the grant so req_ready drops the moment reset asserts.
    assign push = PRESETn && grant_any && !full;
    assign pop  = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign tag_arr[gi]   = req_tag[gi*TAG_W +: TAG_W];
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = push && (grant_idx == SRC_W'(gi));
        end
    endgenerate

    // First asserted valid at or after rr, wrapping at NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_reg} + SUM_W'(k);
            if (scan_sum >= SUM_W'(NUM_REQ)) begin
                scan_sum = scan_sum - SUM_W'(NUM_REQ);
            end
            scan_idx = scan_sum[SRC_W-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign rr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rr_reg     <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                rr_reg     <= rr_next;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage carries no reset; the flushed pointers make old contents unreachable.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= {grant_idx, tag_arr[grant_idx], data_arr[grant_idx]};
        end
    end

    assign {out_src, out_tag, out_data} = mem[rd_ptr_reg];
    assign out_valid = (level_reg != '0);
    assign level     = level_reg;

`ifdef DPI_ARB_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            stall_reg <= '0;
        end else if ((|req_valid) && full && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dpi_txn_arbiter.sv
// Directed bench for dpi_txn_arbiter: a cycle table for arbitration/FIFO flow plus
// hand-written sequences for fill/drain, full-pop corner, mid-run reset and the stall counter.
module tb_dpi_txn_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_tag = '0;
    logic [127:0] req_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_tag;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic [3:0]  level;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    dpi_txn_arbiter dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .out_src   (out_src),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_src;
        logic [3:0] exp_lvl;
    } vec_t;

    vec_t vecs [13];

`ifdef DPI_ARB_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd20;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_table_records();
        for (int i = 0; i < 4; i++) begin
            req_tag[i*8 +: 8]    = 8'hA0 + 8'(i);
            req_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        PRESETn   = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        PRESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int accepts;

        //                 valid    ordy  ready    ov    src   lvl
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 4'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 4'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 4'd1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 4'd1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 4'd1};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'd1};
        vecs[6]  = '{4'b1001, 1'b0, 4'b1000, 1'b0, 2'd0, 4'd0};
        vecs[7]  = '{4'b1001, 1'b0, 4'b0001, 1'b1, 2'd3, 4'd1};
        vecs[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3, 4'd2};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'd2};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 4'd1};
        vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};

        // Reset state, with a requester already asserting valid.
        set_table_records();
        req_valid = 4'b1111;
        repeat (2) tick();
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_stall", 64'(stall_cnt), 64'd0);

        // Single requester 1, tag 0x11 / data 0xDEADBEEF.
        do_reset();
        req_tag[15:8]   = 8'h11;
        req_data[63:32] = 32'hDEAD_BEEF;
        req_valid = 4'b0010;
        out_ready = 1'b1;
        #1;
        chk("single_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("single_ov", 64'(out_valid), 64'd1);
        chk("single_tag", 64'(out_tag), 64'h11);
        chk("single_data", 64'(out_data), 64'hDEADBEEF);
        chk("single_src", 64'(out_src), 64'd1);
        chk("single_lvl1", 64'(level), 64'd1);
        tick();
        chk("single_lvl0", 64'(level), 64'd0);
        chk("single_ov0", 64'(out_valid), 64'd0);
        $display("[TB] single txn: tag %0h data %0h src 1", 8'h11, 32'hDEADBEEF);

        // Cycle table from reset: round-robin order and FIFO flow.
        do_reset();
        set_table_records();
        for (int r = 0; r < 13; r++) begin
            req_valid = vecs[r].valid;
            out_ready = vecs[r].ordy;
            #1;
            chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
            chk($sformatf("row%0d_ov", r), 64'(out_valid), 64'(vecs[r].exp_ov));
            chk($sformatf("row%0d_lvl", r), 64'(level), 64'(vecs[r].exp_lvl));
            if (vecs[r].exp_ov) begin
                chk($sformatf("row%0d_src", r), 64'(out_src), 64'(vecs[r].exp_src));
                chk($sformatf("row%0d_tag", r), 64'(out_tag), 64'(8'hA0 + 8'(vecs[r].exp_src)));
                chk($sformatf("row%0d_data", r), 64'(out_data),
                    64'(32'hC0DE_0000 + 32'(vecs[r].exp_src)));
            end
            $display("[TB] row %0d: valid %b ordy %b ready %b ov %b src %0d lvl %0d",
                     r, req_valid, out_ready, req_ready, out_valid, out_src, level);
            tick();
        end

        // Fill with out_ready low: exactly DEPTH accepts, data numbered by accept order.
        do_reset();
        set_table_records();
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'b0001;
            req_data[31:0] = 32'(accepts);
            #1;
            if (req_ready[0]) accepts++;
            tick();
        end
        chk("fill_accepts", 64'(accepts), 64'd8);
        chk("fill_level", 64'(level), 64'd8);
        chk("fill_ready_low", 64'(req_ready), 64'd0);
        $display("[TB] fill: %0d accepts, level %0d", accepts, level);

        // One-cycle pop while full: no push that cycle, push on the next.
        out_ready = 1'b1;
        #1;
        chk("fullpop_ready", 64'(req_ready), 64'd0);
        chk("fullpop_head", 64'(out_data), 64'd0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("fullpop_lvl7", 64'(level), 64'd7);
        chk("fullpop_ready_next", 64'(req_ready), 64'b0001);
        tick();
        chk("fullpop_lvl8", 64'(level), 64'd8);
        $display("[TB] full pop: level 8 -> 7 -> %0d", level);

        // Drain in push order, then streaming resumes.
        req_valid = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk($sformatf("drain%0d_ov", j), 64'(out_valid), 64'd1);
            chk($sformatf("drain%0d_data", j), 64'(out_data), 64'(j + 1));
            $display("[TB] drain %0d: data %0h src %0d", j, out_data, out_src);
            tick();
        end
        chk("drain_level", 64'(level), 64'd0);
        req_valid = 4'b0001;
        #1;
        chk("resume_ready", 64'(req_ready), 64'b0001);
        tick();

        // Reset mid-operation with level 5.
        do_reset();
        set_table_records();
        req_valid = 4'b0001;
        repeat (5) tick();
        chk("midrst_lvl5", 64'(level), 64'd5);
        PRESETn = 1'b0;
        #1;
        chk("midrst_lvl", 64'(level), 64'd0);
        chk("midrst_ov", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        tick();
        PRESETn = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("midrst_grant0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("midrst_src", 64'(out_src), 64'd0);
        chk("midrst_lvl1", 64'(level), 64'd1);
        $display("[TB] mid reset: first grant src %0d", out_src);

        // Stall counter: full FIFO, requester 2 valid for 20 cycles.
        do_reset();
        set_table_records();
        req_valid = 4'b0001;
        repeat (8) tick();
        req_valid = 4'b0100;
        #1;
        chk("stall_full", 64'(level), 64'd8);
        chk("stall_start", 64'(stall_cnt), 64'd0);
        chk("stall_ready", 64'(req_ready), 64'd0);
        repeat (20) tick();
        req_valid = '0;
        #1;
        chk("stall_20", 64'(stall_cnt), 64'(EXP_STALL));
        tick();
        chk("stall_hold", 64'(stall_cnt), 64'(EXP_STALL));
        $display("[TB] stall: count %0d", stall_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
